zap_wb_arbiter: RTL and testbench

// - Shares one external Wishbone B3 bus between the I-side and D-side zap_cache instances.
// - Each cache presents combinational *_nxt master signals (cache FSM, tag-RAM clean and TLB

---
 rtl/zap_arb_pkg.sv | 25 ++
 rtl/zap_rr_pick.sv | 21 ++
 rtl/zap_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_zap_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_arb_pkg.sv
// Shared types for the I/D Wishbone arbiter: grant encoding and the bus request payload.
package zap_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_grant_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{cyc: 1'b0, stb: 1'b0, wen: 1'b0, sel: 4'h0,
                                        adr: 32'h0, dat: 32'h0, cti: CTI_CLASSIC};

endpackage

// File: rtl/zap_rr_pick.sv
// Two-way requester picker: req[0] is D-side, req[1] is I-side; last=1 means I won last.
module zap_rr_pick
    import zap_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output arb_grant_t pick
);

    always_comb begin
        pick = ARB_IDLE;
        case (req)
            2'b01:   pick = ARB_D;
            2'b10:   pick = ARB_I;
            2'b11:   pick = (mode || last) ? ARB_D : ARB_I;
            default: pick = ARB_IDLE;
        endcase
    end

endmodule

// File: rtl/zap_wb_arbiter.sv
// Shares one Wishbone bus between the I-side and D-side caches; grants per cycle,
// registers the owner's next-cycle signals onto the bus and routes ACK back.
module zap_wb_arbiter
    import zap_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_d_wb_cyc,
    input  logic        i_d_wb_stb,
    input  logic        i_d_wb_wen,
    input  logic [3:0]  i_d_wb_sel,
    input  logic [31:0] i_d_wb_adr,
    input  logic [31:0] i_d_wb_dat,
    input  logic [2:0]  i_d_wb_cti,
    output logic        o_d_wb_ack,
    input  logic        i_i_wb_cyc,
    input  logic        i_i_wb_stb,
    input  logic        i_i_wb_wen,
    input  logic [3:0]  i_i_wb_sel,
    input  logic [31:0] i_i_wb_adr,
    input  logic [31:0] i_i_wb_dat,
    input  logic [2:0]  i_i_wb_cti,
    output logic        o_i_wb_ack,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [2:0]  o_wb_cti,
    input  logic        i_wb_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

    wb_req_t          d_req, i_req, bus_d, bus_q;
    arb_grant_t       grant_d, grant_q, pick;
    logic             last_d, last_q;
    logic [WDW-1:0]   wdog_d, wdog_q;
    logic             timeout_d, timeout_q;
    logic             bus_free, owner_cyc;

    assign d_req = '{cyc: i_d_wb_cyc, stb: i_d_wb_stb, wen: i_d_wb_wen, sel: i_d_wb_sel,
                     adr: i_d_wb_adr, dat: i_d_wb_dat, cti: i_d_wb_cti};
    assign i_req = '{cyc: i_i_wb_cyc, stb: i_i_wb_stb, wen: i_i_wb_wen, sel: i_i_wb_sel,
                     adr: i_i_wb_adr, dat: i_i_wb_dat, cti: i_i_wb_cti};

    assign bus_free = !bus_q.stb || i_wb_ack;

    zap_rr_pick u_pick (
        .req  ({i_req.cyc, d_req.cyc}),
        .last (last_q),
        .mode (ARB_MODE != 0),
        .pick (pick)
    );

    // Re-arbitrate only on a free bus and only once the owner has let go of cyc.
    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        owner_cyc = 1'b0;
        bus_d     = WB_REQ_IDLE;
        case (grant_q)
            ARB_D:   owner_cyc = d_req.cyc;
            ARB_I:   owner_cyc = i_req.cyc;
            default: owner_cyc = 1'b0;
        endcase
        if (bus_free && !owner_cyc) begin
            grant_d = pick;
        end
        if ((grant_d != grant_q) && (grant_d != ARB_IDLE)) begin
            last_d = (grant_d == ARB_I);
        end
        case (grant_d)
            ARB_D:   bus_d = d_req;
            ARB_I:   bus_d = i_req;
            default: bus_d = WB_REQ_IDLE;
        endcase
    end

    // Watchdog: counts unacknowledged strobe cycles, pulses and restarts on expiry.
    always_comb begin
        wdog_d    = '0;
        timeout_d = 1'b0;
        if (bus_q.stb && !i_wb_ack) begin
            if (wdog_q == WDW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WDW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus_q     <= WB_REQ_IDLE;
            grant_q   <= ARB_IDLE;
            last_q    <= 1'b1;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            bus_q     <= bus_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_wb_cyc   = bus_q.cyc;
    assign o_wb_stb   = bus_q.stb;
    assign o_wb_wen   = bus_q.wen;
    assign o_wb_sel   = bus_q.sel;
    assign o_wb_adr   = bus_q.adr;
    assign o_wb_dat   = bus_q.dat;
    assign o_wb_cti   = bus_q.cti;
    assign o_grant    = grant_q;
    assign o_timeout  = timeout_q;
    assign o_d_wb_ack = i_wb_ack & (grant_q == ARB_D);
    assign o_i_wb_ack = i_wb_ack & (grant_q == ARB_I);

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed bench for zap_wb_arbiter: round-robin, fixed-priority and short-watchdog instances
// share one set of master/slave stimulus.
module tb_zap_wb_arbiter;

    localparam logic [2:0] CTI_BURST = 3'b010;
    localparam logic [2:0] CTI_EOB   = 3'b111;

    logic        clk, rst_n, wb_ack;
    logic        d_cyc, d_stb, d_wen, i_cyc, i_stb, i_wen;
    logic [3:0]  d_sel, i_sel;
    logic [31:0] d_adr, d_dat, i_adr, i_dat;
    logic [2:0]  d_cti, i_cti;

    logic        rr_cyc, rr_stb, rr_wen, rr_d_ack, rr_i_ack, rr_timeout;
    logic [3:0]  rr_sel;
    logic [31:0] rr_adr, rr_dat;
    logic [2:0]  rr_cti;
    logic [1:0]  rr_grant;
    logic        fp_cyc, fp_stb, fp_wen, fp_d_ack, fp_i_ack, fp_timeout;
    logic [3:0]  fp_sel;
    logic [31:0] fp_adr, fp_dat;
    logic [2:0]  fp_cti;
    logic [1:0]  fp_grant;
    logic        to_cyc, to_stb, to_wen, to_d_ack, to_i_ack, to_timeout;
    logic [3:0]  to_sel;
    logic [31:0] to_adr, to_dat;
    logic [2:0]  to_cti;
    logic [1:0]  to_grant;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    zap_wb_arbiter u_rr (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen), .i_d_wb_sel(d_sel),
        .i_d_wb_adr(d_adr), .i_d_wb_dat(d_dat), .i_d_wb_cti(d_cti), .o_d_wb_ack(rr_d_ack),
        .i_i_wb_cyc(i_cyc), .i_i_wb_stb(i_stb), .i_i_wb_wen(i_wen), .i_i_wb_sel(i_sel),
        .i_i_wb_adr(i_adr), .i_i_wb_dat(i_dat), .i_i_wb_cti(i_cti), .o_i_wb_ack(rr_i_ack),
        .o_wb_cyc(rr_cyc), .o_wb_stb(rr_stb), .o_wb_wen(rr_wen), .o_wb_sel(rr_sel),
        .o_wb_adr(rr_adr), .o_wb_dat(rr_dat), .o_wb_cti(rr_cti), .i_wb_ack(wb_ack),
        .o_grant(rr_grant), .o_timeout(rr_timeout)
    );

    zap_wb_arbiter #(.ARB_MODE(1)) u_fp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen), .i_d_wb_sel(d_sel),
        .i_d_wb_adr(d_adr), .i_d_wb_dat(d_dat), .i_d_wb_cti(d_cti), .o_d_wb_ack(fp_d_ack),
        .i_i_wb_cyc(i_cyc), .i_i_wb_stb(i_stb), .i_i_wb_wen(i_wen), .i_i_wb_sel(i_sel),
        .i_i_wb_adr(i_adr), .i_i_wb_dat(i_dat), .i_i_wb_cti(i_cti), .o_i_wb_ack(fp_i_ack),
        .o_wb_cyc(fp_cyc), .o_wb_stb(fp_stb), .o_wb_wen(fp_wen), .o_wb_sel(fp_sel),
        .o_wb_adr(fp_adr), .o_wb_dat(fp_dat), .o_wb_cti(fp_cti), .i_wb_ack(wb_ack),
        .o_grant(fp_grant), .o_timeout(fp_timeout)
    );

    zap_wb_arbiter #(.TIMEOUT(4)) u_to (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_wen(d_wen), .i_d_wb_sel(d_sel),
        .i_d_wb_adr(d_adr), .i_d_wb_dat(d_dat), .i_d_wb_cti(d_cti), .o_d_wb_ack(to_d_ack),
        .i_i_wb_cyc(i_cyc), .i_i_wb_stb(i_stb), .i_i_wb_wen(i_wen), .i_i_wb_sel(i_sel),
        .i_i_wb_adr(i_adr), .i_i_wb_dat(i_dat), .i_i_wb_cti(i_cti), .o_i_wb_ack(to_i_ack),
        .o_wb_cyc(to_cyc), .o_wb_stb(to_stb), .o_wb_wen(to_wen), .o_wb_sel(to_sel),
        .o_wb_adr(to_adr), .o_wb_dat(to_dat), .o_wb_cti(to_cti), .i_wb_ack(wb_ack),
        .o_grant(to_grant), .o_timeout(to_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_cyc = 1'b0; d_stb = 1'b0; d_wen = 1'b0; d_sel = 4'h0; d_adr = '0; d_dat = '0; d_cti = 3'b000;
        i_cyc = 1'b0; i_stb = 1'b0; i_wen = 1'b0; i_sel = 4'h0; i_adr = '0; i_dat = '0; i_cti = 3'b000;
        wb_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'hdead_0000;
        wb_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rr_cyc !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b want=0", rr_cyc); end
        total++; if (rr_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", rr_stb); end
        total++; if (rr_adr !== 32'h0) begin bad++; $display("FAIL reset_adr got=%h want=0", rr_adr); end
        total++; if (rr_cti !== 3'b000) begin bad++; $display("FAIL reset_cti got=%b want=000", rr_cti); end
        total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", rr_grant); end
        total++; if (rr_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", rr_timeout); end
        total++; if ({rr_d_ack, rr_i_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {rr_d_ack, rr_i_ack}); end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_d_read();
        do_reset();
        tick();
        d_cyc = 1'b1; d_stb = 1'b1; d_sel = 4'hf; d_adr = 32'h0000_1000;
        tick();
        total++; if (rr_adr !== 32'h0000_1000) begin bad++; $display("FAIL dread_adr got=%h want=00001000", rr_adr); end
        total++; if ({rr_cyc, rr_stb} !== 2'b11) begin bad++; $display("FAIL dread_cycstb got=%b want=11", {rr_cyc, rr_stb}); end
        total++; if (rr_grant !== 2'd1) begin bad++; $display("FAIL dread_grant got=%0d want=1", rr_grant); end
        total++; if (rr_sel !== 4'hf) begin bad++; $display("FAIL dread_sel got=%h want=f", rr_sel); end
        tick();
        total++; if (rr_grant !== 2'd1) begin bad++; $display("FAIL dread_hold got=%0d want=1", rr_grant); end
        wb_ack = 1'b1;
        d_cyc = 1'b0; d_stb = 1'b0;
        #1;
        total++; if (rr_d_ack !== 1'b1) begin bad++; $display("FAIL dread_dack got=%b want=1", rr_d_ack); end
        total++; if (rr_i_ack !== 1'b0) begin bad++; $display("FAIL dread_iack got=%b want=0", rr_i_ack); end
        tick();
        wb_ack = 1'b0;
        total++; if (rr_cyc !== 1'b0) begin bad++; $display("FAIL dread_release_cyc got=%b want=0", rr_cyc); end
        total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL dread_release_grant got=%0d want=0", rr_grant); end
    endtask

    task automatic test_ties();
        logic [1:0] exp_rr [3];
        exp_rr[0] = 2'd1; exp_rr[1] = 2'd2; exp_rr[2] = 2'd1;
        do_reset();
        tick();
        for (int r = 0; r < 3; r++) begin
            d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h0000_0100;
            i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0200;
            tick();
            total++; if (rr_grant !== exp_rr[r]) begin bad++; $display("FAIL tie_rr_grant round=%0d got=%0d want=%0d", r, rr_grant, exp_rr[r]); end
            total++; if (rr_adr !== ((exp_rr[r] == 2'd1) ? 32'h100 : 32'h200)) begin bad++; $display("FAIL tie_rr_adr round=%0d got=%h want_grant=%0d", r, rr_adr, exp_rr[r]); end
            total++; if (fp_grant !== 2'd1) begin bad++; $display("FAIL tie_fp_grant round=%0d got=%0d want=1", r, fp_grant); end
            total++; if (fp_adr !== 32'h100) begin bad++; $display("FAIL tie_fp_adr round=%0d got=%h want=00000100", r, fp_adr); end
            wb_ack = 1'b1;
            idle_inputs();
            wb_ack = 1'b1;
            #1;
            total++; if ({rr_d_ack, rr_i_ack} !== ((exp_rr[r] == 2'd1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_rr_ackroute round=%0d got=%b", r, {rr_d_ack, rr_i_ack}); end
            total++; if ({fp_d_ack, fp_i_ack} !== 2'b10) begin bad++; $display("FAIL tie_fp_ackroute round=%0d got=%b want=10", r, {fp_d_ack, fp_i_ack}); end
            tick();
            wb_ack = 1'b0;
            total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL tie_idle round=%0d got=%0d want=0", r, rr_grant); end
        end
    endtask

    task automatic test_burst();
        do_reset();
        tick();
        i_cyc = 1'b1; i_stb = 1'b1; i_sel = 4'hf; i_adr = 32'h0000_2000; i_cti = CTI_BURST;
        tick();
        for (int k = 0; k < 8; k++) begin
            total++; if (rr_adr !== 32'h0000_2000 + 32'(4 * k)) begin bad++; $display("FAIL burst_adr beat=%0d got=%h want=%h", k, rr_adr, 32'h0000_2000 + 32'(4 * k)); end
            total++; if (rr_cti !== ((k < 7) ? CTI_BURST : CTI_EOB)) begin bad++; $display("FAIL burst_cti beat=%0d got=%b", k, rr_cti); end
            total++; if (rr_grant !== 2'd2) begin bad++; $display("FAIL burst_grant beat=%0d got=%0d want=2", k, rr_grant); end
            if (k == 2) begin
                d_cyc = 1'b1; d_stb = 1'b1; d_sel = 4'h3; d_adr = 32'h0000_3000;
            end
            wb_ack = 1'b1;
            if (k < 7) begin
                i_adr = 32'h0000_2000 + 32'(4 * (k + 1));
                i_cti = (k + 1 == 7) ? CTI_EOB : CTI_BURST;
            end else begin
                i_cyc = 1'b0; i_stb = 1'b0; i_cti = 3'b000;
            end
            #1;
            total++; if ({rr_d_ack, rr_i_ack} !== 2'b01) begin bad++; $display("FAIL burst_ack beat=%0d got=%b want=01", k, {rr_d_ack, rr_i_ack}); end
            tick();
        end
        wb_ack = 1'b0;
        total++; if (rr_adr !== 32'h0000_3000) begin bad++; $display("FAIL burst_handoff_adr got=%h want=00003000", rr_adr); end
        total++; if (rr_grant !== 2'd1) begin bad++; $display("FAIL burst_handoff_grant got=%0d want=1", rr_grant); end
        total++; if (rr_cyc !== 1'b1) begin bad++; $display("FAIL burst_handoff_cyc got=%b want=1", rr_cyc); end
        wb_ack = 1'b1;
        d_cyc = 1'b0; d_stb = 1'b0;
        tick();
        wb_ack = 1'b0;
    endtask

    task automatic test_stray_ack();
        do_reset();
        tick();
        wb_ack = 1'b1;
        #1;
        total++; if ({rr_d_ack, rr_i_ack} !== 2'b00) begin bad++; $display("FAIL stray_acks got=%b want=00", {rr_d_ack, rr_i_ack}); end
        tick();
        tick();
        total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL stray_grant got=%0d want=0", rr_grant); end
        total++; if (rr_cyc !== 1'b0) begin bad++; $display("FAIL stray_cyc got=%b want=0", rr_cyc); end
        wb_ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h0000_4000;
        tick();
        for (int n = 1; n <= 12; n++) begin
            tick();
            total++; if (to_timeout !== ((n % 4) == 0)) begin bad++; $display("FAIL timeout_pulse cycle=%0d got=%b want=%b", n, to_timeout, (n % 4) == 0); end
            total++; if (to_grant !== 2'd1) begin bad++; $display("FAIL timeout_grant cycle=%0d got=%0d want=1", n, to_grant); end
            total++; if (rr_timeout !== 1'b0) begin bad++; $display("FAIL timeout_long cycle=%0d got=%b want=0", n, rr_timeout); end
        end
        wb_ack = 1'b1;
        d_cyc = 1'b0; d_stb = 1'b0;
        tick();
        wb_ack = 1'b0;
        total++; if (to_grant !== 2'd0) begin bad++; $display("FAIL timeout_release got=%0d want=0", to_grant); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick();
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_2000; i_cti = CTI_BURST;
        tick();
        wb_ack = 1'b1;
        i_adr = 32'h0000_2004;
        tick();
        total++; if (rr_adr !== 32'h0000_2004) begin bad++; $display("FAIL midrst_pre_adr got=%h want=00002004", rr_adr); end
        rst_n = 1'b0;
        #1;
        total++; if ({rr_cyc, rr_stb} !== 2'b00) begin bad++; $display("FAIL midrst_cycstb got=%b want=00", {rr_cyc, rr_stb}); end
        total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL midrst_grant got=%0d want=0", rr_grant); end
        total++; if (rr_i_ack !== 1'b0) begin bad++; $display("FAIL midrst_iack got=%b want=0", rr_i_ack); end
        idle_inputs();
        #1;
        rst_n = 1'b1;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h0000_5000;
        tick();
        total++; if (rr_grant !== 2'd1) begin bad++; $display("FAIL midrst_regrant got=%0d want=1", rr_grant); end
        total++; if (rr_adr !== 32'h0000_5000) begin bad++; $display("FAIL midrst_adr got=%h want=00005000", rr_adr); end
        wb_ack = 1'b1;
        d_cyc = 1'b0; d_stb = 1'b0;
        tick();
        wb_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_d_read();
        test_ties();
        test_burst();
        test_stray_ack();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
